mux_scan_n: RTL and testbench
=============================

// Module: mux_scan_n
// PURPOSE
//  Parametrised N-to-1 registered multiplexer with a built-in channel sequencer; successor to the fixed 8:1 mux.
//  Selects one W-bit channel, either by direct select (manual mode) or by an auto-scan pointer (scan mode).
//  Output is registered and carries a valid/ready handshake, so it can feed a serial display or logger stage.
// PARAMETERS
//  N      8              number of input channels, 2..64
//  W      1              bits per channel
//  SEL_W  $clog2(N)      select/pointer width (derived, do not override)
//  DWELL  1              accepted samples per channel before the scan pointer advances, >=1
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous reset, active-low
//  mode       in   1      0 = manual (sel_in), 1 = auto-scan
//  sel_in     in   SEL_W  manual channel select
//  data_in    in   N*W    channel k occupies data_in[k*W +: W]
//  out_ready  in   1      downstream accepts out_data this cycle
//  out_data   out  W      registered selected channel data
//  out_sel    out  SEL_W  channel index that out_data came from
//  out_valid  out  1      out_data/out_sel hold a sample
//  ch_mask    in   N      (MUX_SCAN_MASK_EN only) 1 = channel enabled
// BEHAVIOUR
//  Reset (async, rst_n=0): out_data=0, out_sel=0, out_valid=0, scan ptr=0, dwell cnt=0, state=IDLE.
//  States:
//   - IDLE: out_valid=0. On the next clk edge, captures the selected channel and goes to RUN.
//   - RUN: out_valid=1.
//     - out_ready=1: captures a new sample at the edge and stays in RUN.
//     - out_ready=0: goes to STALL.
//   - STALL: out_valid=1; out_data, out_sel, ptr and dwell cnt all hold. On out_ready=1, captures at the edge and returns to RUN.
//  Capture ("accept" = out_valid=0 or out_ready=1 at the edge):
//   - idx = mode ? ptr : sel_in; out_data <= data_in[idx*W +: W]; out_sel <= idx.
//   - Latency is 1 cycle from data_in/sel_in to out_data.
//  Manual: sel_in >= N selects channel 0 (out_sel=0).
//  Scan: on each accepted capture, dwell cnt increments.
//   - At DWELL-1, cnt clears and ptr advances; ptr wraps N-1 -> 0.
//   - DWELL=1 gives a new channel every accepted cycle.
//  Mode change is sampled at the edge:
//   - 1->0: ptr and dwell cnt freeze.
//   - 0->1: ptr and dwell cnt clear to 0; the first scan capture is channel 0.
//  A stall during a mode change holds the output; the new mode applies at the next accept.
//  rst_n asserted mid-stall drops out_valid immediately and discards the held sample.
//  No combinational path from out_ready to out_data.
// CONFIGURATION
//  MUX_SCAN_MASK_EN defined: ch_mask port exists.
//   - Scan: ptr advances to the next enabled channel (cyclic). If ptr's own channel is disabled, it first moves to the next enabled one.
//   - Manual: selecting a disabled channel captures out_data=0, out_sel=idx.
//   - ch_mask=0 in scan mode: no capture; state forced to IDLE (out_valid=0) until some bit is set.
//  MUX_SCAN_MASK_EN undefined: no ch_mask port; all N channels enabled; behaviour as above.
// TESTING
//  1. Reset: rst_n=0 with data active -> out_valid=0, out_data=0, out_sel=0; release -> out_valid=1 after 1 edge.
//  2. Manual: N=8, W=4, data_in ch k = k+1, out_ready=1, sel_in=5 -> out_data=6, out_sel=5 one edge later; sel_in=9 (SEL_W=4 build) -> out_sel=0.
//  3. Scan: DWELL=2, out_ready=1 -> out_sel sequence 0,0,1,1,..,7,7,0 (wrap checked).
//  4. Stall: scan mode with out_ready=0 for 3 cycles at out_sel=3 -> out_data/out_sel hold 3; ready=1 -> next capture resumes the sequence without skipping.
//  5. Mode switch: scan at ptr=4, mode->0 with sel_in=2 -> out_sel=2; mode->1 -> out_sel restarts at 0.
//  6. MASK_EN: ch_mask=8'b1010_0100 scan -> out_sel 2,5,7,2; ch_mask=0 -> out_valid=0 next edge.

Source files
------------

// File: rtl/mux_scan_n.sv
// N-to-1 registered mux with manual select or auto-scan pointer, valid/ready output.
// Optional per-channel enable mask when MUX_SCAN_MASK_EN is defined (adds i_ch_mask).
module mux_scan_n #(
  parameter int N     = 8,
  parameter int W     = 1,
  parameter int SEL_W = $clog2(N),
  parameter int DWELL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_mode,
  input  logic [SEL_W-1:0] i_sel_in,
  input  logic [N*W-1:0]   i_data_in,
  input  logic             i_out_ready,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N-1:0]     i_ch_mask,
`endif
  output logic [W-1:0]     o_out_data,
  output logic [SEL_W-1:0] o_out_sel,
  output logic             o_out_valid
);
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  state_t           r_state, w_state_nxt;
  logic [W-1:0]     r_out_data;
  logic [SEL_W-1:0] r_out_sel, r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mode;

  logic [N-1:0]     w_mask;
  logic             w_any, w_scan_start, w_accept, w_hold_idle, w_cap, w_wrap;
  logic [SEL_W-1:0] w_ptr_base, w_cur, w_nxt, w_man, w_idx;
  logic [CNT_W-1:0] w_cnt_base;
  logic [W-1:0]     w_data;
  int               w_best_c, w_dist_c, w_best_n, w_dist_n;

`ifdef MUX_SCAN_MASK_EN
  assign w_mask = i_ch_mask;
`else
  assign w_mask = '1;
`endif

  assign w_any        = |w_mask;
  // A rising mode edge restarts the scan from channel 0 even if this edge is not an accept.
  assign w_scan_start = i_mode & ~r_mode;
  assign w_ptr_base   = w_scan_start ? '0 : r_ptr;
  assign w_cnt_base   = w_scan_start ? '0 : r_cnt;
  assign w_accept     = (r_state == IDLE) | i_out_ready;
  assign w_hold_idle  = i_mode & ~w_any;
  assign w_cap        = w_accept & ~w_hold_idle;
  assign w_wrap       = (w_cnt_base == CNT_W'(DWELL - 1));

  // First enabled channel at or after the pointer (cyclic distance search).
  always_comb begin
    w_cur    = w_ptr_base;
    w_best_c = N;
    w_dist_c = 0;
    for (int k = 0; k < N; k++) begin
      w_dist_c = (k - int'(w_ptr_base) + N) % N;
      if (w_mask[k] && (w_dist_c < w_best_c)) begin
        w_best_c = w_dist_c;
        w_cur    = SEL_W'(k);
      end
    end
  end

  // First enabled channel strictly after w_cur; w_cur itself if it is the only one.
  always_comb begin
    w_nxt    = w_cur;
    w_best_n = N;
    w_dist_n = 0;
    for (int k = 0; k < N; k++) begin
      w_dist_n = (k - int'(w_cur) - 1 + 2 * N) % N;
      if (w_mask[k] && (w_dist_n < w_best_n)) begin
        w_best_n = w_dist_n;
        w_nxt    = SEL_W'(k);
      end
    end
  end

  assign w_man = (int'(i_sel_in) < N) ? i_sel_in : '0;
  assign w_idx = i_mode ? w_cur : w_man;

  always_comb begin
    w_data = '0;
    for (int k = 0; k < N; k++)
      if ((w_idx == SEL_W'(k)) && w_mask[k]) w_data = i_data_in[k*W +: W];
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:       if (!w_hold_idle) w_state_nxt = RUN;
      RUN, STALL: begin
        if (w_hold_idle)      w_state_nxt = IDLE;
        else if (i_out_ready) w_state_nxt = RUN;
        else                  w_state_nxt = STALL;
      end
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_out_data <= '0;
      r_out_sel  <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_mode     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= i_mode;
      if (w_cap) begin
        r_out_data <= w_data;
        r_out_sel  <= w_idx;
      end
      if (i_mode) begin
        if (w_cap) begin
          if (w_wrap) begin
            r_cnt <= '0;
            r_ptr <= w_nxt;
          end else begin
            r_cnt <= w_cnt_base + 1'b1;
            r_ptr <= w_cur;
          end
        end else begin
          r_cnt <= w_cnt_base;
          r_ptr <= w_ptr_base;
        end
      end
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_sel   = r_out_sel;
  assign o_out_valid = (r_state != IDLE);
endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: N=8, W=4, DWELL=2, SEL_W widened to 4 to reach sel_in >= N.
module tb_mux_scan_n;
  localparam int N = 8, W = 4, SEL_W = 4, DWELL = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mode;
  logic [SEL_W-1:0] sel_in;
  logic [N*W-1:0]   data_in;
  logic             out_ready;
  logic [N-1:0]     ch_mask;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_sel;
  logic             out_valid;

  int checks = 0;
  int errors = 0;

  mux_scan_n #(.N(N), .W(W), .SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .i_mode(mode), .i_sel_in(sel_in), .i_data_in(data_in),
    .i_out_ready(out_ready),
`ifdef MUX_SCAN_MASK_EN
    .i_ch_mask(ch_mask),
`endif
    .o_out_data(out_data), .o_out_sel(out_sel), .o_out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input int s, input int d);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".sel"},   32'(out_sel),   32'(s));
    chk({tag, ".data"},  32'(out_data),  32'(d));
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel_in = 4'd5; out_ready = 1'b1;
    data_in = 32'h8765_4321;  // channel k carries k+1
    ch_mask = '1;

    // Reset holds outputs clear even with live inputs
    step(); step();
    chk_out("reset", 1'b0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    step();
    chk_out("rel_sel5", 1'b1, 5, 6);

    // Manual select, including out-of-range select
    sel_in = 4'd9;  step(); chk_out("man_sel9", 1'b1, 0, 1);
    sel_in = 4'd3;  step(); chk_out("man_sel3", 1'b1, 3, 4);
    sel_in = 4'd15; step(); chk_out("man_sel15", 1'b1, 0, 1);
    sel_in = 4'd7;  step(); chk_out("man_sel7", 1'b1, 7, 8);

    // Scan with DWELL=2: 0,0,1,1,...,7,7,0,0,1,1,2,2,3 (wrap included)
    mode = 1'b1;
    for (int i = 0; i <= 22; i++) begin
      step();
      chk_out($sformatf("scan%0d", i), 1'b1, (i / 2) % 8, (i / 2) % 8 + 1);
    end

    // Stall for three cycles at channel 3, then resume without skipping
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_out($sformatf("stall%0d", i), 1'b1, 3, 4);
    end
    out_ready = 1'b1;
    step(); chk_out("resume3", 1'b1, 3, 4);
    step(); chk_out("resume4a", 1'b1, 4, 5);
    step(); chk_out("resume4b", 1'b1, 4, 5);

    // Mode switch to manual then back to scan restarts at channel 0
    mode = 1'b0; sel_in = 4'd2;
    step(); chk_out("sw_man2", 1'b1, 2, 3);
    mode = 1'b1;
    step(); chk_out("sw_scan0a", 1'b1, 0, 1);
    step(); chk_out("sw_scan0b", 1'b1, 0, 1);
    step(); chk_out("sw_scan1", 1'b1, 1, 2);

    // Rising mode edge during a stall: output holds, scan restarts at 0 on next accept
    mode = 1'b0; sel_in = 4'd6;
    step(); chk_out("st_man6", 1'b1, 6, 7);
    out_ready = 1'b0; mode = 1'b1;
    step(); chk_out("st_hold6", 1'b1, 6, 7);
    out_ready = 1'b1;
    step(); chk_out("st_scan0", 1'b1, 0, 1);

    // Reset asserted mid-stall drops valid without waiting for an edge
    out_ready = 1'b0;
    step(); chk_out("pre_rst", 1'b1, 0, 1);
    #2 rst_n = 1'b0;
    #1 chk_out("mid_rst", 1'b0, 0, 0);
    @(negedge clk); rst_n = 1'b1; mode = 1'b0; sel_in = 4'd1; out_ready = 1'b1;
    step(); chk_out("post_rst", 1'b1, 1, 2);

`ifdef MUX_SCAN_MASK_EN
    // Enabled channels 2,5,7 with DWELL=2: 2,2,5,5,7,7,2
    ch_mask = 8'b1010_0100; mode = 1'b1;
    step(); chk_out("mask2a", 1'b1, 2, 3);
    step(); chk_out("mask2b", 1'b1, 2, 3);
    step(); chk_out("mask5a", 1'b1, 5, 6);
    step(); chk_out("mask5b", 1'b1, 5, 6);
    step(); chk_out("mask7a", 1'b1, 7, 8);
    step(); chk_out("mask7b", 1'b1, 7, 8);
    step(); chk_out("mask2c", 1'b1, 2, 3);
    ch_mask = '0;
    step(); chk("mask0.valid", 32'(out_valid), 32'd0);
    ch_mask = 8'b1010_0100; mode = 1'b0; sel_in = 4'd3;
    step(); chk_out("mask_man_off", 1'b1, 3, 0);
    sel_in = 4'd5;
    step(); chk_out("mask_man_on", 1'b1, 5, 6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
